// File: rtl/res4_serie_if.sv
// Start/busy/done handshake and operand/result bundle
// for the bit-serial 4-bit subtractor.
interface res4_serie_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] Resta;
  logic       Borrow;

  modport master (
    output start, A, B,
    input  busy, done, Resta, Borrow
  );

  modport slave (
    input  start, A, B,
    output busy, done, Resta, Borrow
  );
endinterface

// File: rtl/res4_serie.sv
// Bit-serial 4-bit subtractor: one full-subtractor
// cell plus a borrow flop, LSB first, 4 cycles/op.
module res4_serie (
  input  logic         clk,
  input  logic         rst_n,
  res4_serie_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] opa_q, opa_d;
  logic [3:0] opb_q, opb_d;
  logic [3:0] acc_q, acc_d;
  logic       br_q, br_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] resta_q, resta_d;
  logic       borrow_q, borrow_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       bit_d;
  logic       bit_br;

  assign bit_d  = opa_q[0] ^ opb_q[0] ^ br_q;
  assign bit_br = (~opa_q[0] & opb_q[0]) |
                  (~(opa_q[0] ^ opb_q[0]) & br_q);

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    resta_d  = resta_q;
    borrow_d = borrow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          opa_d   = bus.A;
          opb_d   = bus.B;
          br_d    = 1'b0;
          cnt_d   = 2'd0;
          acc_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        br_d  = bit_br;
        acc_d = {bit_d, acc_q[3:1]};
        opa_d = {1'b0, opa_q[3:1]};
        opb_d = {1'b0, opb_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          resta_d  = {bit_d, acc_q[3:1]};
          borrow_d = bit_br;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= 4'd0;
      opb_q    <= 4'd0;
      acc_q    <= 4'd0;
      br_q     <= 1'b0;
      cnt_q    <= 2'd0;
      resta_q  <= 4'd0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      resta_q  <= resta_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.Resta  = resta_q;
  assign bus.Borrow = borrow_q;

endmodule

// File: tb/tb_res4_serie.sv
// Directed self-checking bench for res4_serie.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_res4_serie;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  res4_serie_if bus ();

  res4_serie dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and wait (bounded) for done.
  task automatic do_op(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] r,
    output logic       bw,
    output int         lat,
    output int         busyc,
    output int         both
  );
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat   = 0;
    busyc = 0;
    both  = 0;
    r     = 4'bx;
    bw    = 1'bx;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy) busyc++;
      tick();
      if (bus.busy && bus.done) both++;
      if (bus.done) begin
        lat = i + 1;
        r   = bus.Resta;
        bw  = bus.Borrow;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = 4'd0;
    bus.B     = 4'd0;
    repeat (2) tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b exp=0", bus.done);
    end
    checks++;
    if (bus.Resta !== 4'd0) begin
      errors++;
      $display("FAIL reset_resta got=%h exp=0", bus.Resta);
    end
    checks++;
    if (bus.Borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_borrow got=%b exp=0", bus.Borrow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] r;
    logic bw;
    int lat, bc, both;
    do_op(4'd9, 4'd3, r, bw, lat, bc, both);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL basic_latency got=%0d exp=4", lat);
    end
    checks++;
    if (bc !== 4) begin
      errors++;
      $display("FAIL basic_busy_cycles got=%0d exp=4", bc);
    end
    checks++;
    if (both !== 0) begin
      errors++;
      $display("FAIL basic_busy_done_overlap got=%0d exp=0", both);
    end
    checks++;
    if (r !== 4'd6 || bw !== 1'b0) begin
      errors++;
      $display("FAIL basic_9m3 got=%h/%b exp=6/0", r, bw);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse done=%b busy=%b exp=0/0",
               bus.done, bus.busy);
    end
    checks++;
    if (bus.Resta !== 4'd6) begin
      errors++;
      $display("FAIL basic_hold got=%h exp=6", bus.Resta);
    end
  endtask

  task automatic test_vectors();
    logic [3:0] va [3] = '{4'd3, 4'd0, 4'd0};
    logic [3:0] vb [3] = '{4'd9, 4'd1, 4'd0};
    logic [3:0] vr [3] = '{4'hA, 4'hF, 4'h0};
    logic       vw [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] r;
    logic bw;
    int lat, bc, both;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], r, bw, lat, bc, both);
      checks++;
      if (lat !== 4 || r !== vr[i] || bw !== vw[i]) begin
        errors++;
        $display("FAIL vec%0d a=%h b=%h got=%h/%b lat=%0d exp=%h/%b lat=4",
                 i, va[i], vb[i], r, bw, lat, vr[i], vw[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] r, er;
    logic bw, ew;
    logic [4:0] diff;
    int lat, bc, both;
    int bad;
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(4'(a), 4'(b), r, bw, lat, bc, both);
        diff = {1'b0, 4'(a)} - {1'b0, 4'(b)};
        er = diff[3:0];
        ew = (a < b);
        checks++;
        if (lat !== 4 || r !== er || bw !== ew || both !== 0) begin
          errors++;
          bad++;
          if (bad < 8)
            $display("FAIL sweep a=%0d b=%0d got=%h/%b lat=%0d exp=%h/%b lat=4",
                     a, b, r, bw, lat, er, ew);
        end
      end
    end
  endtask

  task automatic test_ignore();
    int lat;
    tick();
    bus.A     = 4'd12;
    bus.B     = 4'd5;
    bus.start = 1'b1;
    tick();
    bus.A = 4'd1;
    bus.B = 4'd2;
    tick();
    tick();
    bus.start = 1'b0;
    lat = 2;
    for (int i = 0; i < 10 && !bus.done; i++) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4 || bus.Resta !== 4'd7 || bus.Borrow !== 1'b0) begin
      errors++;
      $display("FAIL ignore got=%h/%b lat=%0d exp=7/0 lat=4",
               bus.Resta, bus.Borrow, lat);
    end
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle busy=%b done=%b exp=0/0",
               bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.A     = 4'd15;
    bus.B     = 4'd15;
    bus.start = 1'b1;
    tick();
    lat = 0;
    for (int i = 0; i < 10 && !bus.done; i++) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4 || bus.Resta !== 4'd0 || bus.Borrow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got=%h/%b lat=%0d exp=0/0 lat=4",
               bus.Resta, bus.Borrow, lat);
    end
    bus.A = 4'd4;
    bus.B = 4'd7;
    tick();
    bus.start = 1'b0;
    lat = 1;
    for (int i = 0; i < 10 && !bus.done; i++) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 5 || bus.Resta !== 4'd13 || bus.Borrow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got=%h/%b gap=%0d exp=d/1 gap=5",
               bus.Resta, bus.Borrow, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] r;
    logic bw;
    int lat, bc, both, seen;
    tick();
    bus.A     = 4'd6;
    bus.B     = 4'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.Resta !== 4'd0 || bus.Borrow !== 1'b0) begin
      errors++;
      $display("FAIL midreset busy=%b done=%b r=%h bw=%b exp=0/0/0/0",
               bus.busy, bus.done, bus.Resta, bus.Borrow);
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_quiet got=%0d exp=0", seen);
    end
    do_op(4'd8, 4'd3, r, bw, lat, bc, both);
    checks++;
    if (lat !== 4 || r !== 4'd5 || bw !== 1'b0) begin
      errors++;
      $display("FAIL midreset_next got=%h/%b lat=%0d exp=5/0 lat=4",
               r, bw, lat);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_sweep();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
